// File: rtl/latency_meter_pkg.sv
// latency_meter_pkg
//   Shared types and width helpers for the latency meter slice.
//   - state_t        : measurement FSM states
//   - cntr_width()   : latency counter / result width for a given MAX_LAT
//   - trials_width() : width of the completed-trials counter for N_TRIALS
package latency_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    PULSE,
    WAIT,
    DONE
  } state_t;

  localparam int DEFAULT_MAX_LAT  = 1024;
  localparam int DEFAULT_N_TRIALS = 4;
  localparam int DEFAULT_GUARD    = 4;

  function automatic int cntr_width(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  function automatic int trials_width(input int n_trials);
    return $clog2(n_trials + 1);
  endfunction

endpackage

// File: rtl/latency_meter_minmax.sv
// lat_minmax_tracker
//   Holds the last / minimum / maximum latency results of a campaign.
//   Ports:
//     clk, rst  : clock, synchronous active-high reset (all results to 0)
//     clear     : start of campaign; min to all-ones, max to 0, last kept
//     update    : a trial completed with the given latency
//     latency   : measured latency of the completing trial
//     lat_last, lat_min, lat_max : registered results
//   clear and update are expected to be already qualified by the clock enable.
module lat_minmax_tracker #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         update,
  input  logic [W-1:0] latency,
  output logic [W-1:0] lat_last,
  output logic [W-1:0] lat_min,
  output logic [W-1:0] lat_max
);

  // lat_last is deliberately not cleared at campaign start: it always names
  // the most recent completed trial, even across a campaign that times out.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_last <= '0;
      lat_min  <= '0;
      lat_max  <= '0;
    end else if (clear) begin
      lat_min <= '1;
      lat_max <= '0;
    end else if (update) begin
      lat_last <= latency;
      if (latency < lat_min) lat_min <= latency;
      if (latency > lat_max) lat_max <= latency;
    end
  end

endmodule

// File: rtl/latency_meter.sv
// latency_meter
//   Sends a one-cycle marker into a delay path and counts cycles until it
//   returns, repeated N_TRIALS times per start request.
//   Ports:
//     clk, rst    : clock, synchronous active-high reset
//     ena         : clock enable; 0 freezes everything including probe_out
//     start       : measurement request, accepted in IDLE only
//     probe_out   : registered marker into the path under test
//     probe_in    : marker returning from the path
//     busy        : campaign in progress (accepted start through done)
//     done        : one ena-cycle pulse at end of campaign
//     timeout     : sticky error, cleared by the next accepted start
//     lat_last/lat_min/lat_max : results, CNTR_W wide
//     trials_done : completed trials in the current campaign
module latency_meter
  import latency_meter_pkg::*;
#(
  parameter int MAX_LAT  = DEFAULT_MAX_LAT,
  parameter int CNTR_W   = cntr_width(MAX_LAT),
  parameter int N_TRIALS = DEFAULT_N_TRIALS,
  parameter int GUARD    = DEFAULT_GUARD
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ena,
  input  logic                              start,
  output logic                              probe_out,
  input  logic                              probe_in,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout,
  output logic [CNTR_W-1:0]                 lat_last,
  output logic [CNTR_W-1:0]                 lat_min,
  output logic [CNTR_W-1:0]                 lat_max,
  output logic [trials_width(N_TRIALS)-1:0] trials_done
);

  localparam int TRIALS_W = trials_width(N_TRIALS);
  localparam int QUIET_W  = $clog2(GUARD + 1);

  localparam logic [CNTR_W-1:0]   CNT_LIMIT   = CNTR_W'(MAX_LAT);
  localparam logic [QUIET_W-1:0]  QUIET_LAST  = QUIET_W'(GUARD - 1);
  localparam logic [TRIALS_W-1:0] TRIALS_LAST = TRIALS_W'(N_TRIALS - 1);

  state_t              state;
  logic [CNTR_W-1:0]   cnt;
  logic [QUIET_W-1:0]  quiet;
  logic                accept;
  logic                echo;

  // cnt is 0 throughout PULSE, so it directly equals the trial latency
  // whether the echo arrives in PULSE or in WAIT.
  assign accept = ena & start & (state == IDLE);
  assign echo   = ena & probe_in & ((state == PULSE) | (state == WAIT));

  lat_minmax_tracker #(
    .W(CNTR_W)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .update   (echo),
    .latency  (cnt),
    .lat_last (lat_last),
    .lat_min  (lat_min),
    .lat_max  (lat_max)
  );

  // done is raised on the edge entering DONE and dropped on the edge leaving
  // it, so busy still covers the done pulse. In FLUSH the guard check has
  // priority over the timeout check.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      probe_out   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      trials_done <= '0;
      cnt         <= '0;
      quiet       <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (start) begin
            state       <= FLUSH;
            busy        <= 1'b1;
            timeout     <= 1'b0;
            trials_done <= '0;
            cnt         <= '0;
            quiet       <= '0;
          end
        end

        FLUSH: begin
          if (!probe_in && (quiet == QUIET_LAST)) begin
            state     <= PULSE;
            probe_out <= 1'b1;
            cnt       <= '0;
          end else if (cnt == CNT_LIMIT) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            quiet <= probe_in ? '0 : quiet + 1'b1;
          end
        end

        PULSE, WAIT: begin
          probe_out <= 1'b0;
          if (probe_in) begin
            trials_done <= trials_done + 1'b1;
            if (trials_done == TRIALS_LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= FLUSH;
              cnt   <= '0;
              quiet <= '0;
            end
          end else if (state == PULSE) begin
            state <= WAIT;
            cnt   <= CNTR_W'(1);
          end else if (cnt == CNT_LIMIT) begin
            timeout <= 1'b1;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/latency_meter.md
Name: latency_meter

Overview:
- Probe-side counterpart to the static delay/synchronizer chain.
- Drives a single-cycle marker pulse into a delay path under test and counts cycles until the marker returns.
- Repeats over N_TRIALS and reports last, min and max latency.
- Used in bring-up and BIST to verify delay lines, CDC synchronizer chains and RAM-based shifters.

Parameters:
MAX_LAT, 1024, timeout in counted cycles for flush and echo wait
CNTR_W, $clog2(MAX_LAT+1), latency counter/result width
N_TRIALS, 4, measurements per start request (>=1)
GUARD, 4, consecutive low probe_in cycles required before each pulse

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
ena  input  1  clock enable; ena=0 freezes FSM, counters and outputs
start  input  1  measurement request, sampled in IDLE only
probe_out  output  1  marker to path input; registered
probe_in  input  1  marker returning from path output
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse at end of campaign
timeout  output  1  sticky error; cleared on next accepted start
lat_last  output  CNTR_W  latency of most recent completed trial
lat_min  output  CNTR_W  minimum over current campaign
lat_max  output  CNTR_W  maximum over current campaign
trials_done  output  $clog2(N_TRIALS+1)  completed trials in current campaign

Behaviour:
- Reset: state IDLE; probe_out=0, busy=0, done=0, timeout=0, lat_last=0, lat_min=0, lat_max=0, trials_done=0, internal counters=0.
- Reset mid-campaign aborts immediately. probe_out drops the next cycle. No done pulse.
- All state updates are qualified by ena. When ena=0, everything holds, including probe_out. A pulse therefore lasts 1 ena-cycle, which matches how the delay chain advances.
- States: IDLE, FLUSH, PULSE, WAIT, DONE.
- IDLE: on start=1:
  - go to FLUSH; busy<=1, timeout<=0, trials_done<=0, lat_min<=all-ones, lat_max<=0, cnt<=0, quiet<=0.
  - start while busy is ignored.
- FLUSH:
  - quiet counts consecutive probe_in=0 cycles and resets to 0 on probe_in=1; cnt increments every cycle.
  - When quiet reaches GUARD-1 with probe_in=0: go to PULSE with cnt<=0.
  - If cnt reaches MAX_LAT: timeout<=1, go to DONE.
- PULSE (one ena-cycle): probe_out=1. If probe_in=1 this cycle (combinational path), latency=0 and the trial completes. Otherwise go to WAIT with cnt<=1.
- WAIT:
  - probe_out=0. If probe_in=1: latency=cnt and the trial completes.
  - Else cnt increments. If cnt=MAX_LAT without echo: timeout<=1, go to DONE.
- Latency definition: number of clk edges from the edge that raised probe_out to the edge that first samples probe_in=1. A register chain of LENGTH L driven directly from probe_out measures exactly L.
- Trial complete:
  - lat_last<=latency; lat_min<=min(lat_min,latency); lat_max<=max(lat_max,latency); trials_done increments.
  - If trials_done+1==N_TRIALS, go to DONE; else go to FLUSH (quiet<=0, cnt<=0).
- DONE: done=1 for exactly one ena-cycle, busy<=0, then IDLE. Results hold until the next start.
- On timeout, lat_min/lat_max reflect completed trials only. lat_min stays all-ones if no trial completed.
- Comparisons are unsigned, CNTR_W wide. The counter never wraps because it saturates at MAX_LAT via timeout.
- A probe_in held high permanently times out in FLUSH, not WAIT.

Decomposition:
- latency_meter_pkg holds:
  - the state enum typedef (IDLE, FLUSH, PULSE, WAIT, DONE);
  - localparam helpers for CNTR_W and trials-counter width.
- Sub-module lat_minmax_tracker holds the lat_last/min/max registers with clear and update inputs. Everything else stays in the top module.

Test Plan:
- Path = delay LENGTH=2, WIDTH=1, CELLS, ena=1; start pulse -> 4 trials, done once; lat_last=lat_min=lat_max=2, trials_done=4, timeout=0.
- Path = delay LENGTH=0 (wire) -> all latencies 0; PULSE completes each trial directly; lat_max=0.
- Path = delay LENGTH=5, ena toggled 1-0-1-0 shared by meter and delay -> latency=5 in ena-cycles; outputs frozen while ena=0.
- probe_in tied 0, MAX_LAT=16 -> timeout=1 after 16 WAIT cycles; done pulse; trials_done=0, lat_min all-ones.
- probe_in tied 1 -> FLUSH timeout, probe_out never asserted, timeout=1.
- rst asserted during WAIT of trial 2, then new start with LENGTH=3 path -> all outputs zero after reset; new campaign reports 3; a start issued while busy produces no extra done.
